// File: rtl/hit_collector.sv
// hit_collector: scans LANES result words per input beat for leading-zero hits,
// queues {meta, lane, word} records in a FIFO and shifts them out serially, LSB first.
// Optional saturating hit counter: define HIT_CLOLLECTOR_COUNT_EN.
module hit_collector #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned META_W = 16,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned LIDX_W = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int unsigned REC_W  = META_W + LIDX_W + WORD_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*WORD_W-1:0] in_word,
  input  logic [META_W-1:0]       in_meta,
  input  logic [6:0]              cfg_mask_bits,
  input  logic [LANES-1:0]        cfg_lane_en,
  input  logic                    out_req,
  output logic                    out_bit,
  output logic                    out_busy,
  output logic                    out_empty,
  output logic                    out_oflow,
  input  logic                    oflow_clr,
  output logic [15:0]             hit_count
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SCNT_W = $clog2(REC_W + 1);

  // Beat stage: lanes still waiting to be turned into records
  logic [LANES-1:0]        r_pend;
  logic [META_W-1:0]       r_meta;
  logic [LANES*WORD_W-1:0] r_words;

  // Record write register feeding the FIFO
  logic                    r_wr_vld;
  logic [REC_W-1:0]        r_wr_rec;

  // FIFO
  logic [REC_W-1:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic                    r_oflow;

  // Serial output
  logic [REC_W-1:0]        r_sh;
  logic [SCNT_W-1:0]       r_scnt;

  logic [WORD_W-1:0]       w_mask;
  logic [LANES-1:0]        w_hit;
  logic [LANES-1:0]        w_pend_rest;
  logic                    w_sel_vld;
  logic [LIDX_W-1:0]       w_sel_idx;
  logic [WORD_W-1:0]       w_sel_word;
  logic                    w_accept;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_busy;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_drop;

  // Hit detection on the incoming beat; shifts past WORD_W leave an all-ones mask
  always_comb begin
    w_mask = ~({WORD_W{1'b1}} >> cfg_mask_bits);
    w_hit  = '0;
    for (int k = 0; k < LANES; k++) begin
      w_hit[k] = cfg_lane_en[k] && ((in_word[k*WORD_W +: WORD_W] & w_mask) == '0);
    end
  end

  // Lowest-index pending lane is the one turned into a record this cycle
  always_comb begin
    w_sel_idx  = '0;
    w_sel_word = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (r_pend[k]) begin
        w_sel_idx  = LIDX_W'(k);
        w_sel_word = r_words[k*WORD_W +: WORD_W];
      end
    end
  end

  assign w_sel_vld   = |r_pend;
  assign w_pend_rest = r_pend & (r_pend - LANES'(1));

  // Ready only while at most one lane (stage or write register) is still unwritten
  assign in_ready = ~(|w_pend_rest) & ~(w_sel_vld & r_wr_vld);
  assign w_accept = in_valid & in_ready;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_busy  = (r_scnt != '0);
  assign w_pop   = out_req & ~w_empty & ~w_busy;
  assign w_push  = r_wr_vld & (~w_full | w_pop);
  assign w_drop  = r_wr_vld & w_full & ~w_pop;

  // Stage register: load a new beat or retire the lane just selected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_meta  <= '0;
      r_words <= '0;
    end else if (w_accept) begin
      r_pend  <= w_hit;
      r_meta  <= in_meta;
      r_words <= in_word;
    end else begin
      r_pend  <= w_pend_rest;
    end
  end

  // Record write register: one record per cycle toward the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_vld <= 1'b0;
      r_wr_rec <= '0;
    end else begin
      r_wr_vld <= w_sel_vld;
      r_wr_rec <= {r_meta, w_sel_idx, w_sel_word};
    end
  end

  // FIFO storage; contents need no reset since pointers and count gate every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_wr_rec;
    end
  end

  // FIFO pointers, occupancy and sticky overflow (a drop beats a same-cycle clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_oflow  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
      if (w_drop) begin
        r_oflow <= 1'b1;
      end else if (oflow_clr) begin
        r_oflow <= 1'b0;
      end
    end
  end

  // Serialiser: load the FIFO head on a pop, then shift REC_W bits out LSB first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh   <= '0;
      r_scnt <= '0;
    end else if (w_pop) begin
      r_sh   <= r_mem[r_rd_ptr];
      r_scnt <= SCNT_W'(REC_W);
    end else if (w_busy) begin
      r_sh   <= r_sh >> 1;
      r_scnt <= r_scnt - SCNT_W'(1);
    end
  end

  assign out_bit   = w_busy & r_sh[0];
  assign out_busy  = w_busy;
  assign out_empty = w_empty;
  assign out_oflow = r_oflow;

`ifdef HIT_CLOLLECTOR_COUNT_EN
  logic [15:0] r_hit_cnt;

  // Count every hit reaching the FIFO write port, kept or dropped; saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt <= '0;
    end else if (r_wr_vld && (r_hit_cnt != 16'hFFFF)) begin
      r_hit_cnt <= r_hit_cnt + 16'd1;
    end
  end

  assign hit_count = r_hit_cnt;
`else
  assign hit_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hit_collector.sv
// tb_hit_collector: directed beats with hand-computed records pushed to a scoreboard
// queue; a monitor reassembles each serial record and compares it to the queue head.
module tb_hit_collector;

  localparam int LANES  = 4;
  localparam int WORD_W = 32;
  localparam int META_W = 16;
  localparam int DEPTH  = 16;
  localparam int REC_W  = 50;

`ifdef HIT_CLOLLECTOR_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  typedef logic [REC_W-1:0] rec_t;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*WORD_W-1:0] in_word;
  logic [META_W-1:0]       in_meta;
  logic [6:0]              cfg_mask_bits;
  logic [LANES-1:0]        cfg_lane_en;
  logic                    out_req;
  logic                    out_bit;
  logic                    out_busy;
  logic                    out_empty;
  logic                    out_oflow;
  logic                    oflow_clr;
  logic [15:0]             hit_count;

  rec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  hit_collector #(
    .LANES (LANES),
    .WORD_W(WORD_W),
    .META_W(META_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_word      (in_word),
    .in_meta      (in_meta),
    .cfg_mask_bits(cfg_mask_bits),
    .cfg_lane_en  (cfg_lane_en),
    .out_req      (out_req),
    .out_bit      (out_bit),
    .out_busy     (out_busy),
    .out_empty    (out_empty),
    .out_oflow    (out_oflow),
    .oflow_clr    (oflow_clr),
    .hit_count    (hit_count)
  );

  function automatic rec_t mk(input logic [15:0] m, input logic [1:0] l, input logic [31:0] w);
    return {m, l, w};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a beat until accepted; returns in the cycle after acceptance
  task automatic send_beat(input logic [15:0] meta, input logic [127:0] words);
    int n = 0;
    in_word  = words;
    in_meta  = meta;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      timeout("send_beat");
      in_valid = 1'b0;
      return;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic read_one();
    int n = 0;
    while ((out_busy || out_empty) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      timeout("read_ready");
      return;
    end
    out_req = 1'b1;
    step();
    out_req = 1'b0;
    n = 0;
    while (out_busy && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) timeout("read_busy");
  endtask

  task automatic drain();
    int g = 0;
    while (!out_empty && g < 40) begin
      read_one();
      g++;
    end
  endtask

  // Monitor: reassemble serial records and compare against the scoreboard head
  rec_t m_exp;
  rec_t m_got;
  int   m_idx;
  bit   m_act = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0;
    end else if (m_act) begin
      if (!out_busy) begin
        timeout("busy_short");
        m_act = 1'b0;
      end else begin
        m_got[m_idx] = out_bit;
        m_idx++;
        if (m_idx == REC_W) begin
          check("record", 64'(m_got), 64'(m_exp));
          m_act = 1'b0;
        end
      end
    end else if (out_busy) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_record: got busy with empty scoreboard, required idle");
        m_exp = '0;
      end else begin
        m_exp = exp_q.pop_front();
      end
      m_got    = '0;
      m_got[0] = out_bit;
      m_idx    = 1;
      m_act    = 1'b1;
    end else begin
      check("idle_bit", 64'(out_bit), 64'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w;
    int           lane;
    in_valid      = 1'b0;
    in_word       = '0;
    in_meta       = '0;
    cfg_mask_bits = 7'd30;
    cfg_lane_en   = 4'hF;
    out_req       = 1'b0;
    oflow_clr     = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_empty", 64'(out_empty), 64'd1);
    check("rst_busy", 64'(out_busy), 64'd0);
    check("rst_bit", 64'(out_bit), 64'd0);
    check("rst_oflow", 64'(out_oflow), 64'd0);
    check("rst_count", 64'(hit_count), 64'd0);
    rst_n = 1'b1;
    step();

    // Single hit on lane 2, empty flag timing
    exp_q.push_back(mk(16'h1234, 2'd2, 32'h0000_0003));
    send_beat(16'h1234, {32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    check("a_ready_t1", 64'(in_ready), 64'd1);
    check("a_empty_t1", 64'(out_empty), 64'd1);
    step();
    check("a_empty_t2", 64'(out_empty), 64'd1);
    step();
    check("a_empty_t3", 64'(out_empty), 64'd0);

    // Mask of zero: only the enabled lane hits
    cfg_mask_bits = 7'd0;
    cfg_lane_en   = 4'b0100;
    exp_q.push_back(mk(16'hBEEF, 2'd2, 32'hDEAD_BEEF));
    send_beat(16'hBEEF, {32'h1111_1111, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333});
    repeat (3) step();

    // Readout at r; a second request at r+5 must be ignored
    out_req = 1'b1;
    step();
    out_req = 1'b0;
    check("r1_busy", 64'(out_busy), 64'd1);
    check("r1_empty", 64'(out_empty), 64'd0);
    repeat (4) step();
    out_req = 1'b1;
    step();
    out_req = 1'b0;
    repeat (44) step();
    check("r50_busy", 64'(out_busy), 64'd1);
    step();
    check("r51_busy", 64'(out_busy), 64'd0);
    check("r51_empty", 64'(out_empty), 64'd0);
    step();
    check("r52_busy", 64'(out_busy), 64'd0);
    read_one();

    // Beat with no hit writes nothing
    cfg_mask_bits = 7'd32;
    cfg_lane_en   = 4'hF;
    send_beat(16'h0BAD, {32'h1, 32'h1, 32'h1, 32'h1});
    check("nohit_ready", 64'(in_ready), 64'd1);
    repeat (2) step();
    check("nohit_empty", 64'(out_empty), 64'd1);

    // All four lanes hit: backpressure while lanes remain
    cfg_mask_bits = 7'd30;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(16'h5555, 2'(i), 32'(i)));
    send_beat(16'h5555, {32'd3, 32'd2, 32'd1, 32'd0});
    step();
    check("q_ready_t2", 64'(in_ready), 64'd0);
    step();
    check("q_ready_t3", 64'(in_ready), 64'd0);
    check("q_empty_t3", 64'(out_empty), 64'd0);
    step();
    check("q_ready_t4", 64'(in_ready), 64'd0);
    step();
    check("q_ready_t5", 64'(in_ready), 64'd1);

    // Mask wider than the word: only all-zero words hit
    cfg_mask_bits = 7'd40;
    exp_q.push_back(mk(16'h0040, 2'd0, 32'h0));
    exp_q.push_back(mk(16'h0040, 2'd2, 32'h0));
    send_beat(16'h0040, {32'h8000_0000, 32'h0, 32'h1, 32'h0});
    repeat (4) step();

    // Lane enables with mask zero
    cfg_mask_bits = 7'd0;
    cfg_lane_en   = 4'b1010;
    exp_q.push_back(mk(16'h00A5, 2'd1, 32'hCCCC_0001));
    exp_q.push_back(mk(16'h00A5, 2'd3, 32'hAAAA_0003));
    send_beat(16'h00A5, {32'hAAAA_0003, 32'hBBBB_0002, 32'hCCCC_0001, 32'hDDDD_0000});
    repeat (4) step();

    // Four-bit mask boundary
    cfg_mask_bits = 7'd4;
    cfg_lane_en   = 4'hF;
    exp_q.push_back(mk(16'h0004, 2'd0, 32'h0FFF_FFFF));
    exp_q.push_back(mk(16'h0004, 2'd2, 32'h0800_0000));
    send_beat(16'h0004, {32'hF000_0000, 32'h0800_0000, 32'h1FFF_FFFF, 32'h0FFF_FFFF});
    repeat (4) step();
    drain();
    check("drain1_empty", 64'(out_empty), 64'd1);

    // 17 single-hit beats into a 16-deep FIFO with no reads
    cfg_mask_bits = 7'd30;
    for (int i = 0; i < 17; i++) begin
      lane = i % 4;
      w = '1;
      w[lane*32 +: 32] = 32'(lane);
      if (i < 16) exp_q.push_back(mk(16'hA000 + 16'(i), 2'(lane), 32'(lane)));
      send_beat(16'hA000 + 16'(i), w);
    end
    repeat (4) step();
    check("of_oflow", 64'(out_oflow), 64'd1);
    check("of_empty", 64'(out_empty), 64'd0);
    check("of_count", 64'(hit_count), CountEn ? 64'd17 : 64'd0);
    oflow_clr = 1'b1;
    step();
    oflow_clr = 1'b0;
    check("of_clr", 64'(out_oflow), 64'd0);

    // Full FIFO: write and pop in the same cycle
    exp_q.push_back(mk(16'hC001, 2'd1, 32'h1));
    send_beat(16'hC001, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF});
    step();
    out_req = 1'b1;
    step();
    out_req = 1'b0;
    check("wp_oflow", 64'(out_oflow), 64'd0);
    check("wp_busy", 64'(out_busy), 64'd1);

    // Still full: a drop with a same-cycle clear leaves the flag set
    send_beat(16'hD0D0, {32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    step();
    oflow_clr = 1'b1;
    step();
    oflow_clr = 1'b0;
    check("clr_prio", 64'(out_oflow), 64'd1);
    check("clr_count", 64'(hit_count), CountEn ? 64'd19 : 64'd0);
    drain();
    check("drain2_empty", 64'(out_empty), 64'd1);

    // Reset in the middle of a shift with a second record and pending lanes
    exp_q.push_back(mk(16'hE001, 2'd1, 32'h2));
    exp_q.push_back(mk(16'hE002, 2'd0, 32'h1));
    send_beat(16'hE001, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF});
    send_beat(16'hE002, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1});
    repeat (3) step();
    out_req = 1'b1;
    step();
    out_req = 1'b0;
    repeat (18) step();
    in_word  = {32'd3, 32'd2, 32'd1, 32'd0};
    in_meta  = 16'hE0E0;
    in_valid = 1'b1;
    check("rs_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rs_bit", 64'(out_bit), 64'd0);
    check("rs_busy", 64'(out_busy), 64'd0);
    check("rs_empty", 64'(out_empty), 64'd1);
    check("rs_ready2", 64'(in_ready), 64'd1);
    check("rs_oflow", 64'(out_oflow), 64'd0);
    check("rs_count", 64'(hit_count), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (60) step();
    check("post_rs_empty", 64'(out_empty), 64'd1);
    check("post_rs_busy", 64'(out_busy), 64'd0);

    // Normal operation after reset
    exp_q.push_back(mk(16'hF00D, 2'd3, 32'h0));
    send_beat(16'hF00D, {32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    repeat (3) step();
    read_one();

    begin
      int n = 0;
      while ((exp_q.size() != 0 || m_act) && n < 200) begin
        step();
        n++;
      end
    end
    check("leftover", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hit_collector.md
HIT_COLLECTOR -- requirements
Module: hit_collector

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel result words per input beat (1..8).
REQ-002 SHALL have parameter WORD_W, default 32, result word width (8..64).
REQ-003 SHALL have parameter META_W, default 16, metadata width carried with each beat.
REQ-004 SHALL have parameter DEPTH, default 16, hit FIFO entries, power of two (4..64).
REQ-005 SHALL define the derived widths LIDX_W = max(1, clog2(LANES)) and REC_W = META_W + LIDX_W + WORD_W.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1, input beat present.
REQ-009 SHALL have port in_ready, output, 1, beat accepted when in_valid && in_ready.
REQ-010 SHALL have port in_word, input, LANES*WORD_W, lane k at bits [k*WORD_W +: WORD_W].
REQ-011 SHALL have port in_meta, input, META_W, beat metadata.
REQ-012 SHALL have port cfg_mask_bits, input, 7, count of leading (MSB) zero bits required for a hit.
REQ-013 SHALL have port cfg_lane_en, input, LANES, per-lane hit enable.
REQ-014 SHALL have port out_req, input, 1, readout request.
REQ-015 SHALL have port out_bit, output, 1, serial record bit.
REQ-016 SHALL have port out_busy, output, 1, serial shift in progress.
REQ-017 SHALL have port out_empty, output, 1, FIFO holds no record.
REQ-018 SHALL have port out_oflow, output, 1, sticky drop flag.
REQ-019 SHALL have port oflow_clr, input, 1, clears out_oflow.
REQ-020 SHALL have port hit_count, output, 16, saturating hit counter (see Configuration).

Function
REQ-021 SHALL form mask = top min(cfg_mask_bits, WORD_W) bits set; lane k hits when (word_k & mask)==0 && cfg_lane_en[k]; cfg_mask_bits=0 -> every enabled lane hits.
REQ-022 SHALL register an accepted beat at cycle t into a stage: pending-hit vector and meta valid from t+1.
REQ-023 SHALL write one record per cycle, lowest-index pending lane first; first write at t+2, next at t+3, and so on.
REQ-024 SHALL format each record as {meta, lane index, word} with word in the LSBs.
REQ-025 SHALL drive in_ready = 1 only when at most one pending lane remains (the one being written this cycle); otherwise 0.
REQ-026 SHALL, on a write while the FIFO is full and no pop occurs in the same cycle, drop the record, set out_oflow, and leave FIFO contents intact.
REQ-027 SHALL accept a write and a pop in the same cycle even when full, leaving the count unchanged.
REQ-028 SHALL drive out_empty = (count==0) from registered count; it deasserts the cycle after the first write.
REQ-029 SHALL, when out_req=1 && !out_empty && !out_busy at cycle r, pop the head into a REC_W shift register.
REQ-030 SHALL, after a pop at cycle r: out_busy=1 for cycles r+1..r+REC_W; out_bit = record bit i at cycle r+1+i (LSB first); out_bit=0 when idle.
REQ-031 SHALL ignore out_req while out_busy=1 or out_empty=1.
REQ-032 SHALL give oflow_clr priority below a same-cycle set: out_oflow remains 1.
REQ-033 SHALL, for a beat with no hits, write nothing; in_ready stays 1.

Reset
REQ-034 SHALL, on rst_n low, asynchronously clear FIFO pointers and count, stage, pending vector, shift register, out_bit, out_busy, out_oflow and hit_count; out_empty=1 and in_ready=1.
REQ-035 SHALL abort any in-flight record shift and pending lanes on reset; nothing is replayed after reset.

Configuration
REQ-036 SHALL, with macro HIT_CLOLLECTOR_COUNT_EN defined, increment hit_count once per written-or-dropped hit, saturating at 16'hFFFF, cleared only by reset.
REQ-037 SHALL, without HIT_CLOLLECTOR_COUNT_EN, tie hit_count to 0 and synthesise no counter.

Verification
REQ-038 SHALL cover LANES=4, WORD_W=32, cfg_mask_bits=30, lane 2 word 0x00000003, meta 0x1234 -> one record 0x1234_2_00000003 (REC_W=50), out_empty low at t+3.
REQ-039 SHALL cover all four lanes hitting in one beat -> writes lanes 0,1,2,3 at t+2..t+5; in_ready low at t+2..t+4.
REQ-040 SHALL cover 17 single-hit beats with DEPTH=16 and no reads -> 16 records kept, out_oflow=1, hit_count=17 with the macro.
REQ-041 SHALL cover out_req at cycle r on a non-empty FIFO -> out_busy high r+1..r+50, bits LSB first; a second out_req at r+5 is ignored.
REQ-042 SHALL cover FIFO full with a write and pop in the same cycle -> count stays 16, out_oflow unchanged.
REQ-043 SHALL cover rst_n low mid-shift at bit 20 -> out_bit=0, out_busy=0 and out_empty=1 immediately; no further bits appear.
